two_bit_comparator_checker: RTL and testbench

Self-checking response monitor for the equality comparator family, sitting on the observation side of the bench opposite the stimulus generator. It samples operand pairs and the DUT's EQ output on a strobe and recomputes the expected result. It counts samples and mismatches, tracks coverage of every operand combination, and reports a pass/fail verdict when the run is stopped. It is synthesizable, so it can also be built as an on-chip BIST observer.

---
 rtl/cmp_chk_pkg.sv | 22 ++
 rtl/cmp_chk_coverage.sv | 49 ++++
 rtl/two_bit_comparator_checker.sv | 161 ++++++++++++++++
 tb/tb_two_bit_comparator_checker.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_chk_pkg.sv
// Shared definitions for the equality-comparator response checker.
//   - state_t      : checker run-state encoding (IDLE/RUN/DRAIN/FINISH)
//   - ERR_MAX      : mismatch counter saturation value
//   - SAMPLE_MAX   : sample counter saturation value
//   - cov_bins()   : number of {A,B} coverage bins for a given operand width
package cmp_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    localparam logic [7:0]  ERR_MAX    = 8'd255;
    localparam logic [15:0] SAMPLE_MAX = 16'd65535;

    function automatic int cov_bins(input int width);
        return 2 ** (2 * width);
    endfunction

endpackage

// File: rtl/cmp_chk_coverage.sv
// Coverage bitmap for the comparator checker.
// One bit per {A,B} combination; bits are set by checked samples, cleared
// together at the start of a run, and AND-reduced into a registered flag.
// Ports:
//   clk, srst  : clock and synchronous active-high reset
//   set_en     : set the bit addressed by set_idx this cycle
//   set_idx    : bin index ({A,B} concatenation)
//   clear_all  : clear every bin (has priority over set_en)
//   covered    : registered AND of all bins
module cmp_chk_coverage #(
    parameter int BINS = 16
) (
    input  logic                    clk,
    input  logic                    srst,
    input  logic                    set_en,
    input  logic [$clog2(BINS)-1:0] set_idx,
    input  logic                    clear_all,
    output logic                    covered
);

    localparam int IDX_W = $clog2(BINS);

    logic [BINS-1:0] bitmap_reg;
    logic [BINS-1:0] bitmap_next;
    logic            covered_reg;

    genvar gi;
    generate
        for (gi = 0; gi < BINS; gi++) begin : g_bin
            assign bitmap_next[gi] = clear_all ? 1'b0
                                   : (bitmap_reg[gi] | (set_en && (set_idx == IDX_W'(gi))));
        end
    endgenerate

    // The flag is reduced from the next-state bitmap so that it becomes
    // visible on the same edge as the bin it depends on.
    always_ff @(posedge clk) begin
        if (srst) begin
            bitmap_reg  <= '0;
            covered_reg <= 1'b0;
        end else begin
            bitmap_reg  <= bitmap_next;
            covered_reg <= &bitmap_next;
        end
    end

    assign covered = covered_reg;

endmodule

// File: rtl/two_bit_comparator_checker.sv
// Self-checking response monitor for an equality comparator.
// Samples {A,B,EQ} on VALID while running, recomputes A==B one cycle later,
// counts samples and mismatches (both saturating), tracks operand coverage
// and reports DONE/PASS once a stopped run has drained.
// Ports:
//   CLK, RST        : clock, synchronous active-high reset
//   START, STOP     : run control pulses
//   VALID, A, B, EQ : observed sample
//   BUSY, DONE      : in RUN/DRAIN, in FINISH
//   PASS            : DONE && no mismatches && full coverage
//   COVERED         : every {A,B} combination seen this run
//   ERR_COUNT       : mismatches (saturating at 255)
//   SAMPLE_COUNT    : accepted samples (saturating at 65535)
// Optional feature macro CMP_CHK_FIRST_FAIL_EN adds FAIL_A, FAIL_B, FAIL_EQ
// and FAIL_SEEN, which hold the first mismatching sample of the run.
module two_bit_comparator_checker
    import cmp_chk_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             STOP,
    input  logic             VALID,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             EQ,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic             COVERED,
    output logic [7:0]       ERR_COUNT,
    output logic [15:0]      SAMPLE_COUNT
`ifdef CMP_CHK_FIRST_FAIL_EN
    ,
    output logic [WIDTH-1:0] FAIL_A,
    output logic [WIDTH-1:0] FAIL_B,
    output logic             FAIL_EQ,
    output logic             FAIL_SEEN
`endif
);

    localparam int BINS = cov_bins(WIDTH);

    state_t state_reg;
    state_t state_next;

    logic             start_run;
    logic             accept;
    logic             mismatch;

    logic             s1_valid_reg;
    logic [WIDTH-1:0] s1_a_reg;
    logic [WIDTH-1:0] s1_b_reg;
    logic             s1_eq_reg;

    logic [7:0]       err_count_reg;
    logic [15:0]      sample_count_reg;

    // START is honoured only from IDLE or FINISH; counters clear on that edge.
    assign start_run = START && ((state_reg == ST_IDLE) || (state_reg == ST_FINISH));
    assign accept    = VALID && (state_reg == ST_RUN);
    assign mismatch  = s1_valid_reg && (s1_eq_reg != (s1_a_reg == s1_b_reg));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (START) state_next = ST_RUN;
            ST_RUN:    if (STOP)  state_next = ST_DRAIN;
            ST_DRAIN:  state_next = ST_FINISH;
            ST_FINISH: if (START) state_next = ST_RUN;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Stage 1: capture the observed sample.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_valid_reg <= 1'b0;
            s1_a_reg     <= '0;
            s1_b_reg     <= '0;
            s1_eq_reg    <= 1'b0;
        end else begin
            s1_valid_reg <= accept;
            if (accept) begin
                s1_a_reg  <= A;
                s1_b_reg  <= B;
                s1_eq_reg <= EQ;
            end
        end
    end

    // Stage 2: check and count. A captured sample can never coincide with
    // start_run because capture only happens in RUN.
    always_ff @(posedge CLK) begin
        if (RST || start_run) begin
            err_count_reg    <= '0;
            sample_count_reg <= '0;
        end else if (s1_valid_reg) begin
            if (sample_count_reg != SAMPLE_MAX) begin
                sample_count_reg <= sample_count_reg + 16'd1;
            end
            if (mismatch && (err_count_reg != ERR_MAX)) begin
                err_count_reg <= err_count_reg + 8'd1;
            end
        end
    end

    cmp_chk_coverage #(
        .BINS (BINS)
    ) u_coverage (
        .clk       (CLK),
        .srst      (RST),
        .set_en    (s1_valid_reg),
        .set_idx   ({s1_a_reg, s1_b_reg}),
        .clear_all (start_run),
        .covered   (COVERED)
    );

`ifdef CMP_CHK_FIRST_FAIL_EN
    logic [WIDTH-1:0] fail_a_reg;
    logic [WIDTH-1:0] fail_b_reg;
    logic             fail_eq_reg;
    logic             fail_seen_reg;

    always_ff @(posedge CLK) begin
        if (RST || start_run) begin
            fail_a_reg    <= '0;
            fail_b_reg    <= '0;
            fail_eq_reg   <= 1'b0;
            fail_seen_reg <= 1'b0;
        end else if (mismatch && !fail_seen_reg) begin
            fail_a_reg    <= s1_a_reg;
            fail_b_reg    <= s1_b_reg;
            fail_eq_reg   <= s1_eq_reg;
            fail_seen_reg <= 1'b1;
        end
    end

    assign FAIL_A    = fail_a_reg;
    assign FAIL_B    = fail_b_reg;
    assign FAIL_EQ   = fail_eq_reg;
    assign FAIL_SEEN = fail_seen_reg;
`endif

    assign BUSY         = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
    assign DONE         = (state_reg == ST_FINISH);
    assign PASS         = DONE && (err_count_reg == 8'd0) && COVERED;
    assign ERR_COUNT    = err_count_reg;
    assign SAMPLE_COUNT = sample_count_reg;

endmodule

// File: tb/tb_two_bit_comparator_checker.sv
// Testbench for two_bit_comparator_checker (WIDTH=2).
// Accepted samples are pushed to a scoreboard queue as they are driven; when
// the run reports DONE the queue is popped into expected counters/coverage
// and compared with the checker outputs.
module tb_two_bit_comparator_checker;

    localparam int WIDTH = 2;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic             START = 1'b0;
    logic             STOP = 1'b0;
    logic             VALID = 1'b0;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic             EQ = 1'b0;
    logic             BUSY;
    logic             DONE;
    logic             PASS;
    logic             COVERED;
    logic [7:0]       ERR_COUNT;
    logic [15:0]      SAMPLE_COUNT;
`ifdef CMP_CHK_FIRST_FAIL_EN
    logic [WIDTH-1:0] FAIL_A;
    logic [WIDTH-1:0] FAIL_B;
    logic             FAIL_EQ;
    logic             FAIL_SEEN;
`endif

    two_bit_comparator_checker #(.WIDTH(WIDTH)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .START        (START),
        .STOP         (STOP),
        .VALID        (VALID),
        .A            (A),
        .B            (B),
        .EQ           (EQ),
        .BUSY         (BUSY),
        .DONE         (DONE),
        .PASS         (PASS),
        .COVERED      (COVERED),
        .ERR_COUNT    (ERR_COUNT),
        .SAMPLE_COUNT (SAMPLE_COUNT)
`ifdef CMP_CHK_FIRST_FAIL_EN
        ,
        .FAIL_A       (FAIL_A),
        .FAIL_B       (FAIL_B),
        .FAIL_EQ      (FAIL_EQ),
        .FAIL_SEEN    (FAIL_SEEN)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       mism;
        logic [3:0] idx;
    } sb_entry_t;

    sb_entry_t   sb[$];
    int          checks = 0;
    int          errors = 0;
    bit          running = 0;
    int          exp_samples;
    int          exp_err;
    logic [15:0] exp_bins;
    logic        exp_covered;
    logic        exp_pass;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Drive one sample for one cycle; record it if the checker should accept it.
    task automatic drive_sample(input logic [1:0] a, input logic [1:0] b, input logic eq);
        sb_entry_t e;
        VALID = 1'b1;
        A     = a;
        B     = b;
        EQ    = eq;
        if (running) begin
            e.mism = (eq != (a == b));
            e.idx  = {a, b};
            sb.push_back(e);
        end
        step();
        VALID = 1'b0;
    endtask

    task automatic do_start();
        START = 1'b1;
        step();
        START = 1'b0;
        running = 1;
    endtask

    // STOP cycle (optionally with no sample) followed by the DRAIN cycle.
    task automatic do_stop();
        STOP = 1'b1;
        step();
        STOP = 1'b0;
        running = 0;
        step();
    endtask

    task automatic sb_drain();
        sb_entry_t e;
        exp_samples = 0;
        exp_err     = 0;
        exp_bins    = '0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (exp_samples != 65535) exp_samples++;
            if (e.mism && exp_err != 255) exp_err++;
            exp_bins[e.idx] = 1'b1;
        end
        exp_covered = &exp_bins;
        exp_pass    = (exp_err == 0) && exp_covered;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) step();
        RST = 1'b0;
        checks++;
        if ({BUSY, DONE, PASS, COVERED, ERR_COUNT, SAMPLE_COUNT} !== 28'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {BUSY, DONE, PASS, COVERED, ERR_COUNT, SAMPLE_COUNT});
        end
        // VALID while IDLE must be ignored.
        for (int i = 0; i < 3; i++) drive_sample(2'(i), 2'(i), 1'b0);
        step();
        step();
        checks++;
        if (SAMPLE_COUNT !== 16'd0 || ERR_COUNT !== 8'd0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL idle_valid_ignored: samples %0d errs %0d busy %b expected 0 0 0",
                     SAMPLE_COUNT, ERR_COUNT, BUSY);
        end
        $display("test_reset done");
    endtask

    task automatic test_exhaustive();
        do_start();
        checks++;
        if (BUSY !== 1'b1 || SAMPLE_COUNT !== 16'd0 || DONE !== 1'b0) begin
            errors++;
            $display("FAIL exh_start: busy %b samples %0d done %b expected 1 0 0",
                     BUSY, SAMPLE_COUNT, DONE);
        end
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                drive_sample(2'(a), 2'(b), a == b);
        STOP = 1'b1;
        step();
        STOP = 1'b0;
        running = 0;
        checks++;
        if (BUSY !== 1'b1 || DONE !== 1'b0) begin
            errors++;
            $display("FAIL exh_drain: busy %b done %b expected 1 0", BUSY, DONE);
        end
        step();
        sb_drain();
        checks++;
        if (DONE !== 1'b1 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL exh_done: done %b busy %b expected 1 0", DONE, BUSY);
        end
        checks++;
        if (SAMPLE_COUNT !== 16'(exp_samples) || ERR_COUNT !== 8'(exp_err)) begin
            errors++;
            $display("FAIL exh_counts: samples %0d errs %0d expected %0d %0d",
                     SAMPLE_COUNT, ERR_COUNT, exp_samples, exp_err);
        end
        checks++;
        if (COVERED !== exp_covered || PASS !== exp_pass) begin
            errors++;
            $display("FAIL exh_verdict: covered %b pass %b expected %b %b",
                     COVERED, PASS, exp_covered, exp_pass);
        end
        $display("test_exhaustive done: samples %0d errs %0d pass %b", SAMPLE_COUNT, ERR_COUNT, PASS);
    endtask

    task automatic test_stuck_eq();
        do_start();
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                drive_sample(2'(a), 2'(b), 1'b0);
        do_stop();
        sb_drain();
        checks++;
        if (ERR_COUNT !== 8'(exp_err) || SAMPLE_COUNT !== 16'(exp_samples)) begin
            errors++;
            $display("FAIL stuck_counts: errs %0d samples %0d expected %0d %0d",
                     ERR_COUNT, SAMPLE_COUNT, exp_err, exp_samples);
        end
        checks++;
        if (PASS !== exp_pass || DONE !== 1'b1 || COVERED !== exp_covered) begin
            errors++;
            $display("FAIL stuck_verdict: pass %b done %b covered %b expected %b 1 %b",
                     PASS, DONE, COVERED, exp_pass, exp_covered);
        end
`ifdef CMP_CHK_FIRST_FAIL_EN
        checks++;
        if (FAIL_SEEN !== 1'b1 || FAIL_A !== 2'd0 || FAIL_B !== 2'd0 || FAIL_EQ !== 1'b0) begin
            errors++;
            $display("FAIL stuck_first_fail: seen %b a %0d b %0d eq %b expected 1 0 0 0",
                     FAIL_SEEN, FAIL_A, FAIL_B, FAIL_EQ);
        end
`endif
        $display("test_stuck_eq done: errs %0d pass %b", ERR_COUNT, PASS);
    endtask

    task automatic test_partial();
        do_start();
        for (int i = 0; i < 10; i++) begin
            // A START mid-run must not restart the counters.
            if (i == 5) START = 1'b1;
            drive_sample(2'd0, 2'd0, 1'b1);
            START = 1'b0;
        end
        do_stop();
        sb_drain();
        checks++;
        if (SAMPLE_COUNT !== 16'(exp_samples) || ERR_COUNT !== 8'(exp_err)) begin
            errors++;
            $display("FAIL partial_counts: samples %0d errs %0d expected %0d %0d",
                     SAMPLE_COUNT, ERR_COUNT, exp_samples, exp_err);
        end
        checks++;
        if (COVERED !== exp_covered || PASS !== exp_pass || DONE !== 1'b1) begin
            errors++;
            $display("FAIL partial_verdict: covered %b pass %b done %b expected %b %b 1",
                     COVERED, PASS, DONE, exp_covered, exp_pass);
        end
        $display("test_partial done: samples %0d covered %b", SAMPLE_COUNT, COVERED);
    endtask

    task automatic test_boundary();
        do_start();
        for (int i = 0; i < 3; i++) drive_sample(2'(i), 2'(i), 1'b1);
        // Wrong sample in the STOP cycle must still be checked.
        STOP = 1'b1;
        drive_sample(2'd1, 2'd2, 1'b1);
        STOP = 1'b0;
        running = 0;
        checks++;
        if (BUSY !== 1'b1 || DONE !== 1'b0) begin
            errors++;
            $display("FAIL bound_drain: busy %b done %b expected 1 0", BUSY, DONE);
        end
        step();
        sb_drain();
        checks++;
        if (ERR_COUNT !== 8'(exp_err) || SAMPLE_COUNT !== 16'(exp_samples) || DONE !== 1'b1) begin
            errors++;
            $display("FAIL bound_stop_sample: errs %0d samples %0d done %b expected %0d %0d 1",
                     ERR_COUNT, SAMPLE_COUNT, DONE, exp_err, exp_samples);
        end
        // VALID and STOP while in FINISH are ignored.
        STOP = 1'b1;
        for (int i = 0; i < 3; i++) drive_sample(2'(i), 2'(i), 1'b0);
        STOP = 1'b0;
        step();
        step();
        checks++;
        if (ERR_COUNT !== 8'(exp_err) || SAMPLE_COUNT !== 16'(exp_samples) || DONE !== 1'b1) begin
            errors++;
            $display("FAIL bound_finish_ignored: errs %0d samples %0d done %b expected %0d %0d 1",
                     ERR_COUNT, SAMPLE_COUNT, DONE, exp_err, exp_samples);
        end
        $display("test_boundary done: errs %0d samples %0d", ERR_COUNT, SAMPLE_COUNT);
    endtask

    task automatic test_back_to_back();
        do_start();
        checks++;
        if (SAMPLE_COUNT !== 16'd0 || ERR_COUNT !== 8'd0 || COVERED !== 1'b0 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL b2b_start_clear: samples %0d errs %0d covered %b busy %b expected 0 0 0 1",
                     SAMPLE_COUNT, ERR_COUNT, COVERED, BUSY);
        end
        for (int i = 0; i < 300; i++) drive_sample(2'd1, 2'd1, 1'b0);
        do_stop();
        sb_drain();
        checks++;
        if (ERR_COUNT !== 8'(exp_err) || SAMPLE_COUNT !== 16'(exp_samples)) begin
            errors++;
            $display("FAIL b2b_saturation: errs %0d samples %0d expected %0d %0d",
                     ERR_COUNT, SAMPLE_COUNT, exp_err, exp_samples);
        end
        checks++;
        if (PASS !== 1'b0 || DONE !== 1'b1) begin
            errors++;
            $display("FAIL b2b_verdict: pass %b done %b expected 0 1", PASS, DONE);
        end
        $display("test_back_to_back done: errs %0d samples %0d", ERR_COUNT, SAMPLE_COUNT);
    endtask

    task automatic test_reset_restart();
        do_start();
        for (int i = 0; i < 5; i++) drive_sample(2'(i), 2'd3, 1'b1);
        // Reset lands while samples are still in flight.
        RST   = 1'b1;
        VALID = 1'b1;
        step();
        RST   = 1'b0;
        VALID = 1'b0;
        running = 0;
        sb.delete();
        checks++;
        if ({BUSY, DONE, PASS, COVERED, ERR_COUNT, SAMPLE_COUNT} !== 28'd0) begin
            errors++;
            $display("FAIL rst_midrun: got %h expected 0",
                     {BUSY, DONE, PASS, COVERED, ERR_COUNT, SAMPLE_COUNT});
        end
        step();
        step();
        checks++;
        if (SAMPLE_COUNT !== 16'd0 || ERR_COUNT !== 8'd0 || COVERED !== 1'b0) begin
            errors++;
            $display("FAIL rst_inflight: samples %0d errs %0d covered %b expected 0 0 0",
                     SAMPLE_COUNT, ERR_COUNT, COVERED);
        end
        do_start();
        do_stop();
        sb_drain();
        checks++;
        if (SAMPLE_COUNT !== 16'(exp_samples) || PASS !== exp_pass || DONE !== 1'b1) begin
            errors++;
            $display("FAIL rst_empty_run: samples %0d pass %b done %b expected %0d %b 1",
                     SAMPLE_COUNT, PASS, DONE, exp_samples, exp_pass);
        end
        $display("test_reset_restart done: samples %0d pass %b", SAMPLE_COUNT, PASS);
    endtask

    initial begin
        test_reset();
        test_exhaustive();
        test_stuck_eq();
        test_partial();
        test_boundary();
        test_back_to_back();
        test_reset_restart();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
